sisc_mc_ctrl: RTL



---
 rtl/sisc_pkg.sv | 34 +++
 rtl/sisc_br_eval.sv | 34 +++
 rtl/sisc_mc_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared opcode, ALU-function and state definitions for the SISC multicycle controller.
package sisc_pkg;

    localparam int NOOP   = 0;
    localparam int LOD    = 1;
    localparam int STR    = 2;
    localparam int SWP    = 3;
    localparam int BRA    = 4;
    localparam int BRR    = 5;
    localparam int BNE    = 6;
    localparam int BNR    = 7;
    localparam int ALU_OP = 8;
    localparam int HLT    = 15;

    localparam int IMM_MODE = 8;

    // ALU functions: register/immediate arithmetic, and register/immediate address calculation
    localparam int ALU_REG      = 0;
    localparam int ALU_IMM      = 1;
    localparam int ALU_ADDR_REG = 2;
    localparam int ALU_ADDR_IMM = 3;

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_WB2,
        ST_HALT
    } state_t;

endpackage

// File: rtl/sisc_br_eval.sv
// Combinational branch evaluation: recognises branch opcodes, decides taken, and selects
// absolute versus relative target mode.
module sisc_br_eval
    import sisc_pkg::*;
#(
    parameter int OP_W = 4,
    parameter int CC_W = 4
) (
    input  logic [OP_W-1:0] opcode,
    input  logic [CC_W-1:0] mm,
    input  logic [CC_W-1:0] stat,
    output logic            is_branch,
    output logic            taken,
    output logic            br_sel
);

    logic cond_hit;

    assign cond_hit = |(stat & mm);

    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        br_sel    = 1'b0;
        case (opcode)
            OP_W'(BRA): begin is_branch = 1'b1; taken =  cond_hit; br_sel = 1'b1; end
            OP_W'(BRR): begin is_branch = 1'b1; taken =  cond_hit; br_sel = 1'b0; end
            OP_W'(BNE): begin is_branch = 1'b1; taken = !cond_hit; br_sel = 1'b1; end
            OP_W'(BNR): begin is_branch = 1'b1; taken = !cond_hit; br_sel = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/sisc_mc_ctrl.sv
// Multicycle SISC control FSM: fetch/decode/execute/memory/writeback sequencing with a
// bounded memory handshake, two-cycle SWP writeback and a sticky HALT state.
module sisc_mc_ctrl
    import sisc_pkg::*;
#(
    parameter int OP_W        = 4,
    parameter int CC_W        = 4,
    parameter int ALU_W       = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [OP_W-1:0]  opcode,
    input  logic [CC_W-1:0]  mm,
    input  logic [CC_W-1:0]  stat,
    input  logic             mem_ack,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             rb_sel,
    output logic [ALU_W-1:0] alu_op,
    output logic             pc_sel,
    output logic             pc_write,
    output logic             pc_rst,
    output logic             br_sel,
    output logic             ir_load,
    output logic             stat_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             halted,
    output logic             mem_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   wait_cnt;
    logic               mem_err_q;
    logic               is_branch, br_taken, br_mode;
    logic               is_imm, is_lod, is_str, is_swp;
    logic               timeout;
    logic [ALU_W-1:0]   addr_alu;

    sisc_br_eval #(
        .OP_W (OP_W),
        .CC_W (CC_W)
    ) u_br_eval (
        .opcode    (opcode),
        .mm        (mm),
        .stat      (stat),
        .is_branch (is_branch),
        .taken     (br_taken),
        .br_sel    (br_mode)
    );

    assign is_imm   = (mm == CC_W'(IMM_MODE));
    assign is_lod   = (opcode == OP_W'(LOD));
    assign is_str   = (opcode == OP_W'(STR));
    assign is_swp   = (opcode == OP_W'(SWP));
    assign addr_alu = is_imm ? ALU_W'(ALU_ADDR_IMM) : ALU_W'(ALU_ADDR_REG);
    // The counter holds the number of ack-less MEM cycles already completed
    assign timeout  = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state     <= ST_START;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state != ST_MEM)
                wait_cnt <= '0;
            else if (wait_cnt != CNT_W'(MEM_TIMEOUT))
                wait_cnt <= wait_cnt + 1'b1;
            if (state == ST_MEM && state_nx == ST_HALT)
                mem_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        rb_sel   = 1'b0;
        alu_op   = '0;
        pc_sel   = 1'b0;
        pc_write = 1'b0;
        pc_rst   = 1'b0;
        br_sel   = 1'b0;
        ir_load  = 1'b0;
        stat_we  = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;
        mem_err  = 1'b0;
        case (state)
            ST_START: begin
                pc_rst   = 1'b1;
                state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_branch) begin
                    br_sel   = br_mode;
                    pc_sel   = br_taken;
                    pc_write = br_taken;
                    state_nx = ST_FETCH;
                end else begin
                    case (opcode)
                        OP_W'(LOD), OP_W'(STR), OP_W'(SWP), OP_W'(ALU_OP): state_nx = ST_EXECUTE;
                        OP_W'(HLT):  state_nx = ST_HALT;
                        OP_W'(NOOP): state_nx = ST_FETCH;
                        default:     state_nx = ST_FETCH;
                    endcase
                end
            end
            ST_EXECUTE: begin
                case (opcode)
                    OP_W'(ALU_OP): begin
                        alu_op   = is_imm ? ALU_W'(ALU_IMM) : ALU_W'(ALU_REG);
                        stat_we  = 1'b1;
                        state_nx = ST_WB;
                    end
                    OP_W'(LOD): begin
                        alu_op   = addr_alu;
                        state_nx = ST_MEM;
                    end
                    OP_W'(STR): begin
                        alu_op   = addr_alu;
                        rb_sel   = 1'b1;
                        state_nx = ST_MEM;
                    end
                    OP_W'(SWP): begin
                        alu_op   = addr_alu;
                        state_nx = ST_WB;
                    end
                    default: state_nx = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_str;
                alu_op  = addr_alu;
                // A late ack in the final allowed cycle still completes the access
                if (mem_ack)
                    state_nx = is_str ? ST_FETCH : ST_WB;
                else if (timeout)
                    state_nx = ST_HALT;
            end
            ST_WB: begin
                rf_we    = 1'b1;
                wb_sel   = is_lod;
                state_nx = is_swp ? ST_WB2 : ST_FETCH;
            end
            ST_WB2: begin
                rf_we    = 1'b1;
                rb_sel   = 1'b1;
                state_nx = ST_FETCH;
            end
            ST_HALT: begin
                halted  = 1'b1;
                mem_err = mem_err_q;
            end
            default: state_nx = ST_START;
        endcase
    end

endmodule
